// File: rtl/modn_updown_counter.sv
// modn_updown_counter: programmable-modulus up/down counter with shadowed modulus
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   en, up, sat     count enable, direction (1 = up), saturate mode (1 = hold at boundary)
//   load, load_val  synchronous load, clamped to the active range
//   mod_wr, mod_in  modulus write request; values below 2 are ignored
//   ovf_clr         clear for the sticky overflow flag
//   q               count value in 0..mod_cur-1
//   tc              terminal count, combinational, cascades into the next stage's en
//   ovf             sticky wrap/saturate flag
//   mod_cur         active modulus
//   mod_pend        a shadow modulus is waiting for a safe boundary
module modn_updown_counter #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_MOD = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             mod_wr,
   input  logic [WIDTH-1:0] mod_in,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf,
   output logic [WIDTH-1:0] mod_cur,
   output logic             mod_pend
);
   logic [WIDTH-1:0] shadow, m_next, m_top, q_cnt, q_nxt;
   logic             term, apply, wr_ok;
   always_comb begin
      term   = up ? (q == mod_cur - 1'b1) : (q == '0);
      tc     = en && !load && term;
      // the shadow modulus is only swapped in where the sequence restarts or is idle
      apply  = mod_pend && (load || !en || tc);
      m_next = apply ? shadow : mod_cur;
      m_top  = m_next - 1'b1;
      wr_ok  = mod_wr && (mod_in >= WIDTH'(2));
      q_cnt  = load ? ((load_val < m_next) ? load_val : m_top)
             : !en  ? q
             : tc   ? (sat ? q : (up ? '0 : m_top))
             : (up ? q + 1'b1 : q - 1'b1);
      // a smaller modulus must pull a held count back into range on the same edge
      q_nxt  = (apply && q_cnt > m_top) ? m_top : q_cnt;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q        <= '0;
         ovf      <= 1'b0;
         mod_cur  <= WIDTH'(DEFAULT_MOD);
         shadow   <= '0;
         mod_pend <= 1'b0;
      end else begin
         q        <= q_nxt;
         ovf      <= tc ? 1'b1 : (ovf_clr ? 1'b0 : ovf);
         mod_cur  <= m_next;
         shadow   <= wr_ok ? mod_in : shadow;
         mod_pend <= wr_ok || (mod_pend && !apply);
      end
   end
endmodule

// File: tb/tb_modn_updown_counter.sv
// tb_modn_updown_counter: directed scoreboard bench for modn_updown_counter (WIDTH=4, DEFAULT_MOD=6)
module tb_modn_updown_counter;
   logic       clk = 0, rst = 1;
   logic       en = 0, up = 0, sat = 0, load = 0, mod_wr = 0, ovf_clr = 0;
   logic [3:0] load_val = 0, mod_in = 0;
   logic [3:0] q0, mc0, q1, mc1;
   logic       tc0, ovf0, pend0, tc1, ovf1, pend1;
   int         n_cmp = 0, n_err = 0;
   string      tag_q[$];
   logic [9:0] exp_q[$];

   always #5 clk = ~clk;

   modn_updown_counter #(.WIDTH(4), .DEFAULT_MOD(6)) u0 (
      .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load), .load_val(load_val),
      .mod_wr(mod_wr), .mod_in(mod_in), .ovf_clr(ovf_clr),
      .q(q0), .tc(tc0), .ovf(ovf0), .mod_cur(mc0), .mod_pend(pend0));

   modn_updown_counter #(.WIDTH(4), .DEFAULT_MOD(6)) u1 (
      .clk(clk), .rst(rst), .en(tc0), .up(1'b1), .sat(1'b0), .load(1'b0), .load_val(4'd0),
      .mod_wr(1'b0), .mod_in(4'd0), .ovf_clr(1'b0),
      .q(q1), .tc(tc1), .ovf(ovf1), .mod_cur(mc1), .mod_pend(pend1));

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input string tag, input logic [3:0] eq, input logic eo,
                       input logic [3:0] em, input logic ep);
      string      t;
      logic [9:0] e;
      tag_q.push_back(tag);
      exp_q.push_back({eq, eo, em, ep});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s: observed empty scoreboard expected entry", tag);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         chk({t, ".q"}, 8'(q0), 8'(e[9:6]));
         chk({t, ".ovf"}, 8'(ovf0), 8'(e[5]));
         chk({t, ".mod_cur"}, 8'(mc0), 8'(e[4:1]));
         chk({t, ".mod_pend"}, 8'(pend0), 8'(e[0]));
      end
   endtask

   initial begin
      #7;
      chk("rst.q", 8'(q0), 0);
      chk("rst.ovf", 8'(ovf0), 0);
      chk("rst.mod_cur", 8'(mc0), 6);
      chk("rst.mod_pend", 8'(pend0), 0);
      #5 rst = 0;
      // wrap counting up
      en = 1; up = 1; sat = 0;
      for (int i = 0; i < 8; i++) begin
         #1 chk("s1.tc", 8'(tc0), 8'((i % 6) == 5));
         tick("s1.cnt", 4'((i + 1) % 6), i >= 5, 6, 0);
      end
      tick("s1.hold_ovf", 3, 1, 6, 0);
      ovf_clr = 1;
      tick("s1.clr", 4, 0, 6, 0);
      ovf_clr = 0;
      // down counting and load clamp
      up = 0; load = 1; load_val = 3;
      #1 chk("s2.tc_load", 8'(tc0), 0);
      tick("s2.load", 3, 0, 6, 0);
      load = 0;
      tick("s2.dn", 2, 0, 6, 0);
      tick("s2.dn", 1, 0, 6, 0);
      tick("s2.dn", 0, 0, 6, 0);
      #1 chk("s2.tc_zero", 8'(tc0), 1);
      tick("s2.wrap", 5, 1, 6, 0);
      tick("s2.dn", 4, 1, 6, 0);
      load = 1; load_val = 9;
      tick("s2.clamp", 5, 1, 6, 0);
      load = 0; en = 0; ovf_clr = 1;
      tick("s3.clr", 5, 0, 6, 0);
      // saturate
      ovf_clr = 0; load = 1; load_val = 4;
      tick("s3.load", 4, 0, 6, 0);
      load = 0; en = 1; up = 1; sat = 1;
      tick("s3.up", 5, 0, 6, 0);
      #1 chk("s3.tc", 8'(tc0), 1);
      tick("s3.sat", 5, 1, 6, 0);
      #1 chk("s3.tc", 8'(tc0), 1);
      tick("s3.sat", 5, 1, 6, 0);
      ovf_clr = 1;
      #1 chk("s3.tc", 8'(tc0), 1);
      tick("s3.set_wins", 5, 1, 6, 0);
      en = 0;
      tick("s3.clr", 5, 0, 6, 0);
      ovf_clr = 0; sat = 0;
      // modulus change deferred to wrap
      load = 1; load_val = 2;
      tick("s4.load", 2, 0, 6, 0);
      load = 0; en = 1; mod_wr = 1; mod_in = 4;
      tick("s4.wr", 3, 0, 6, 1);
      mod_wr = 0;
      tick("s4.pend", 4, 0, 6, 1);
      tick("s4.pend", 5, 0, 6, 1);
      #1 chk("s4.tc", 8'(tc0), 1);
      tick("s4.apply", 0, 1, 4, 0);
      tick("s4.m4", 1, 1, 4, 0);
      tick("s4.m4", 2, 1, 4, 0);
      tick("s4.m4", 3, 1, 4, 0);
      #1 chk("s4.tc_m4", 8'(tc0), 1);
      tick("s4.wrap4", 0, 1, 4, 0);
      // modulus change while idle, clamp, ignore, back-to-back writes
      en = 0; mod_wr = 1; mod_in = 6;
      tick("s5.wr6", 0, 1, 4, 1);
      mod_wr = 0;
      tick("s5.ap6", 0, 1, 6, 0);
      load = 1; load_val = 5;
      tick("s5.load", 5, 1, 6, 0);
      load = 0; mod_wr = 1; mod_in = 3;
      tick("s5.wr3", 5, 1, 6, 1);
      mod_wr = 0;
      tick("s5.ap3", 2, 1, 3, 0);
      mod_wr = 1; mod_in = 1;
      tick("s5.ign", 2, 1, 3, 0);
      mod_in = 5;
      tick("s5.wr5", 2, 1, 3, 1);
      mod_in = 7;
      tick("s5.ap5_wr7", 2, 1, 5, 1);
      mod_wr = 0;
      tick("s5.ap7", 2, 1, 7, 0);
      mod_wr = 1; mod_in = 6;
      tick("s5.wr6b", 2, 1, 7, 1);
      mod_wr = 0;
      tick("s5.ap6b", 2, 1, 6, 0);
      // cascade, then asynchronous reset
      #2 rst = 1;
      #2 rst = 0;
      en = 1; up = 1;
      for (int i = 0; i < 14; i++) begin
         tick("s6.cnt", 4'((i + 1) % 6), i >= 5, 6, 0);
         chk("s6.q1", 8'(q1), 8'((i + 1) / 6));
      end
      mod_wr = 1; mod_in = 4;
      tick("s6.wr", 3, 1, 6, 1);
      mod_wr = 0;
      #3 rst = 1;
      #1;
      chk("s6.rst_q0", 8'(q0), 0);
      chk("s6.rst_q1", 8'(q1), 0);
      chk("s6.rst_ovf", 8'(ovf0), 0);
      chk("s6.rst_mod", 8'(mc0), 6);
      chk("s6.rst_pend", 8'(pend0), 0);
      chk("s6.rst_tc", 8'(tc0), 0);
      #2 rst = 0;
      tick("s6.after", 1, 0, 6, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
